// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a registered, handshaked result.
// Single-cycle ops complete with a one-cycle done pulse.
// Multiply is an iterative shift-add over WIDTH cycles.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       OP,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW  = SHW;
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_MUL  = 4'd1;
    localparam logic [3:0] OP_LAND = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_LOR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [CW-1:0]   cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [WIDTH:0]   add_full;
    logic [PW-1:0]    shl_full;
    logic [SHW-1:0]   sh;
    logic [PW-1:0]    acc_next;

    // OP[4] is reserved and intentionally ignored
    logic unused_op;
    assign unused_op = OP[4];

    // Single-cycle result and error for the current operands
    always_comb begin
        alu_res  = '0;
        alu_err  = 1'b0;
        sh       = B[SHW-1:0];
        add_full = {1'b0, A} + {1'b0, B};
        shl_full = PW'(A) << sh;
        case (OP[3:0])
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_err = add_full[WIDTH];
            end
            OP_LAND: alu_res = WIDTH'((|A) && (|B));
            OP_AND:  alu_res = A & B;
            OP_SUB: begin
                alu_res = A - B;
                alu_err = (A < B);
            end
            OP_LOR:  alu_res = WIDTH'((|A) || (|B));
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SHL: begin
                alu_res = shl_full[WIDTH-1:0];
                alu_err = |shl_full[PW-1:WIDTH];
            end
            OP_SHR:  alu_res = A >> sh;
            OP_MUL:  alu_res = '0;
            default: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next = acc + (mul_b[0] ? mul_a : '0);
    end

    // Control FSM, multiply datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            result <= '0;
            error  <= 1'b0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (OP[3:0] == OP_MUL) begin
                            mul_a <= PW'(A);
                            mul_b <= B;
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end else begin
                            result <= alu_res;
                            error  <= alu_err;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= acc_next;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        result <= acc_next[WIDTH-1:0];
                        error  <= |acc_next[PW-1:WIDTH];
                        zero   <= (acc_next[WIDTH-1:0] == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH = 16).
module tb_alu_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   op;
    logic [W-1:0] result;
    logic         error;
    logic         zero;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (a),
        .B      (b),
        .OP     (op),
        .result (result),
        .error  (error),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op: start sampled at the next edge, outputs checked right after it
    task automatic single(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er, input logic ee);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".done"},   32'(done),   32'd1);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".error"},  32'(error),  32'(ee));
        check({tag, ".zero"},   32'(zero),   32'(er == '0));
        tick();
        check({tag, ".done_off"}, 32'(done), 32'd0);
    endtask

    // Multiply: busy through edge W-1, done exactly at edge W
    task automatic mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ee);
        int bad_busy;
        bad_busy = 0;
        op = 5'd1; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = '0; b = '0; op = 5'd12;
        for (int k = 0; k < int'(W) - 1; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            tick();
        end
        if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
        check({tag, ".busy_window"}, 32'(bad_busy), 32'd0);
        tick();
        check({tag, ".done"},   32'(done),   32'd1);
        check({tag, ".busy"},   32'(busy),   32'd0);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".error"},  32'(error),  32'(ee));
        check({tag, ".zero"},   32'(zero),   32'(er == '0));
        tick();
        check({tag, ".done_off"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dn;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst.result", 32'(result), 32'h0);
        check("rst.error",  32'(error),  32'd0);
        check("rst.zero",   32'(zero),   32'd1);
        check("rst.busy",   32'(busy),   32'd0);
        check("rst.done",   32'(done),   32'd0);
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            a = 16'h1234; b = 16'h0001;
            tick();
            if (done) dn++;
        end
        check("idle.no_done", 32'(dn), 32'd0);

        single("add_carry", 5'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        single("sub_borrow", 5'd4, 16'h0003, 16'h0005, 16'hFFFE, 1'b1);
        single("add_plain", 5'd0, 16'h1234, 16'h0101, 16'h1335, 1'b0);

        // Back-to-back AND then XOR
        op = 5'd3; a = 16'h0F0F; b = 16'h00FF; start = 1'b1;
        tick();
        check("b2b.and.done",   32'(done),   32'd1);
        check("b2b.and.result", 32'(result), 32'h000F);
        op = 5'd7;
        tick();
        start = 1'b0;
        check("b2b.xor.done",   32'(done),   32'd1);
        check("b2b.xor.result", 32'(result), 32'h0FF0);
        tick();
        check("b2b.done_off", 32'(done), 32'd0);

        mul("mul_small", 16'h0012, 16'h0034, 16'h03A8, 1'b0);
        mul("mul_ovf",   16'h0100, 16'h0100, 16'h0000, 1'b1);
        mul("mul_max",   16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);

        // Busy rejection: add start pulsed at edge 5 of a multiply
        op = 5'd1; a = 16'h0003; b = 16'h0004; start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        for (int e = 1; e <= int'(W) + 3; e++) begin
            if (e == 5) begin op = 5'd0; a = 16'h0001; b = 16'h0001; start = 1'b1; end
            else start = 1'b0;
            tick();
            if (done) begin
                dn++;
                check("rej.done_edge", 32'(e), 32'(W));
                check("rej.result", 32'(result), 32'h000C);
            end
        end
        start = 1'b0;
        check("rej.done_count", 32'(dn), 32'd1);

        // Reset mid-multiply at edge 8
        op = 5'd1; a = 16'h0012; b = 16'h0034; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e < 8; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst.busy",   32'(busy),   32'd0);
        check("mrst.result", 32'(result), 32'h0);
        check("mrst.zero",   32'(zero),   32'd1);
        check("mrst.error",  32'(error),  32'd0);
        dn = 0;
        for (int k = 0; k < int'(W) + 4; k++) begin
            if (done) dn++;
            tick();
        end
        check("mrst.no_done", 32'(dn), 32'd0);

        single("land",    5'd2,  16'h0005, 16'h0003, 16'h0001, 1'b0);
        single("land0",   5'd2,  16'h0005, 16'h0000, 16'h0000, 1'b0);
        single("lor",     5'd5,  16'h0005, 16'h0000, 16'h0001, 1'b0);
        single("or",      5'd6,  16'hA000, 16'h0005, 16'hA005, 1'b0);
        single("shl_out", 5'd8,  16'h8001, 16'h0001, 16'h0002, 1'b1);
        single("shl_amt", 5'd8,  16'h0001, 16'h00F4, 16'h0010, 1'b0);
        single("shr",     5'd9,  16'h8000, 16'h000F, 16'h0001, 1'b0);
        single("illegal", 5'd12, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        single("op16add", 5'd16, 16'h0002, 16'h0003, 16'h0005, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
